updown_mod_counter: RTL and testbench

- Parametrised successor to the team's 4-bit free-running up counter.
- Adds up/down direction, a programmable modulus, synchronous parallel load, wrap or saturate mode, a clock-enable prescaler, a terminal-count flag and a registered wrap pulse.
- Drives board LEDs and HEX displays, and serves as the timebase for later timer and FSM labs.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/updown_mod_counter.sv | 87 ++++++++
 tb/tb_updown_mod_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter and its prescaler.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: emits one tick every DIV enabled cycles; clr restarts the phase.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // DIV=1 still needs a 1-bit phase register, which then simply stays at zero.
  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_pcnt;

  // Phase counter advances only while enabled and rolls over at DIV-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pcnt <= '0;
    end else if (clr) begin
      r_pcnt <= '0;
    end else if (en) begin
      if (r_pcnt == LAST) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PW'(1'b1);
      end
    end else begin
      r_pcnt <= r_pcnt;
    end
  end

  assign tick = en && (r_pcnt == LAST);

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MAX with parallel load, wrap or saturate ends,
// a prescaled step enable, a terminal-count flag and a registered wrap pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               DIV      = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  logic             w_tick;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             r_wrap;
  logic             w_wrap_next;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .clr    (load),
    .tick   (w_tick)
  );

  // Next count: load beats step beats hold; a value above MAX counts as MAX going up.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (load) begin
      w_q_next = (load_val > MAX) ? MAX : load_val;
    end else if (w_tick) begin
      if (up == DIR_UP) begin
        if (r_q < MAX) begin
          w_q_next = r_q + ONE;
        end else if (SATURATE) begin
          w_q_next = MAX;
        end else begin
          w_q_next    = ZERO;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (r_q != ZERO) begin
          w_q_next = r_q - ONE;
        end else if (SATURATE) begin
          w_q_next = ZERO;
        end else begin
          w_q_next    = MAX;
          w_wrap_next = 1'b1;
        end
      end
    end else begin
      w_q_next = r_q;
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q    <= ZERO;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = ((up == DIR_UP) && (r_q == MAX)) || ((up == DIR_DOWN) && (r_q == ZERO));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised scoreboard bench: three counter configurations share one stimulus stream.
module tb_updown_mod_counter;

  localparam int NI = 3;
  localparam int P_MAX [NI] = '{9, 9, 7};
  localparam int P_DIV [NI] = '{3, 1, 1};
  localparam int P_SAT [NI] = '{0, 1, 0};

  typedef struct packed {
    logic [NI-1:0][7:0] q;
    logic [NI-1:0]      wr;
    logic [NI-1:0]      tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q0, q1;
  logic [2:0] q2;
  logic       tc0, tc1, tc2, wr0, wr1, wr2;

  logic [7:0] act_q  [NI];
  logic       act_tc [NI];
  logic       act_wr [NI];

  exp_t sb[$];
  int   m_q  [NI];
  int   m_ph [NI];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9), .DIV(3), .SATURATE(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .wrap(wr0));

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9), .DIV(1), .SATURATE(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .wrap(wr1));

  updown_mod_counter #(.WIDTH(3), .DIV(1), .SATURATE(1'b0)) dut2 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(load_val[2:0]), .q(q2), .tc(tc2), .wrap(wr2));

  assign act_q[0] = {4'd0, q0};
  assign act_q[1] = {4'd0, q1};
  assign act_q[2] = {5'd0, q2};
  assign act_tc[0] = tc0;
  assign act_tc[1] = tc1;
  assign act_tc[2] = tc2;
  assign act_wr[0] = wr0;
  assign act_wr[1] = wr1;
  assign act_wr[2] = wr2;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_q[i]  = 0;
      m_ph[i] = 0;
    end
  endtask

  // Reference behaviour: count enabled cycles, step when DIV of them have passed.
  task automatic model_step(input bit ld, input bit ena, input bit dir_up, input int lv,
                            output exp_t e);
    int lvi;
    int nxt;
    bit w;
    for (int i = 0; i < NI; i++) begin
      w   = 1'b0;
      lvi = (i == 2) ? (lv % 8) : lv;
      if (ld) begin
        m_q[i]  = (lvi > P_MAX[i]) ? P_MAX[i] : lvi;
        m_ph[i] = 0;
      end else if (ena) begin
        m_ph[i] = m_ph[i] + 1;
        if (m_ph[i] == P_DIV[i]) begin
          m_ph[i] = 0;
          nxt = dir_up ? m_q[i] + 1 : m_q[i] - 1;
          if (nxt > P_MAX[i]) begin
            if (P_SAT[i] != 0) nxt = P_MAX[i];
            else begin nxt = 0; w = 1'b1; end
          end else if (nxt < 0) begin
            if (P_SAT[i] != 0) nxt = 0;
            else begin nxt = P_MAX[i]; w = 1'b1; end
          end
          m_q[i] = nxt;
        end
      end
      e.q[i]  = 8'(m_q[i]);
      e.wr[i] = w;
      e.tc[i] = dir_up ? (m_q[i] == P_MAX[i]) : (m_q[i] == 0);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
          check($sformatf("q[%0d]", i), int'(act_q[i]), int'(e.q[i]));
          check($sformatf("wrap[%0d]", i), int'(act_wr[i]), int'(e.wr[i]));
          check($sformatf("tc[%0d]", i), int'(act_tc[i]), int'(e.tc[i]));
        end
      end
    end
  end

  initial begin
    exp_t e;
    resetn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_q[%0d]", i), int'(act_q[i]), 0);
      check($sformatf("rst_wrap[%0d]", i), int'(act_wr[i]), 0);
      check($sformatf("rst_tc_up[%0d]", i), int'(act_tc[i]), 0);
    end
    up = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tc_down[%0d]", i), int'(act_tc[i]), 1);
    end
    @(negedge clk);
    resetn = 1'b1;
    up = 1'b1;

    for (int it = 0; it < 800; it++) begin
      if (it != 0) @(negedge clk);
      if (it == 250 || it == 560) begin
        #2 resetn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
          check($sformatf("async_rst_q[%0d]", i), int'(act_q[i]), 0);
          check($sformatf("async_rst_wrap[%0d]", i), int'(act_wr[i]), 0);
        end
        @(negedge clk);
        resetn = 1'b1;
      end
      load     = ($urandom_range(0, 11) == 0);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      load_val = 4'($urandom_range(0, 15));
      model_step(load, en, up, int'(load_val), e);
      sb.push_back(e);
    end

    @(negedge clk);
    load = 1'b0; en = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
